fft_out_sequencer: RTL and testbench
====================================

# fft_out_sequencer

Output-stage controller for the 64-point FFT processor. On a start pulse from the FFT core it reads the 64 result words from the result RAM in natural or bit-reversed address order, optionally divides both halves of each word by 64 (arithmetic shift right by 6), and streams the words out over a valid/ready interface with full backpressure. It owns the output scaling decision for a frame and the result-RAM read port during unload.

## Interface
- N_POINTS, 64, frame length in words
- ADDR_WIDTH, 6, result-RAM address width (log2 N_POINTS)
- DATA_WIDTH, 32, word width; [31:16] real, [15:0] imaginary, two's complement
- SHIFT, 6, right-shift amount applied when scaling is enabled

- Clk  in  1  clock, all state updates on rising edge
- nRst  in  1  asynchronous active-low reset
- Start  in  1  one-cycle pulse: frame ready in result RAM
- Scale_En  in  1  sampled on accepted Start; 1 = scale frame by 2^-SHIFT
- Bit_Rev  in  1  sampled on accepted Start; 1 = read RAM at bit-reversed address
- Busy  out  1  high from cycle after accepted Start until Done
- Done  out  1  one-cycle pulse after last word handshake
- Rd_En  out  1  result-RAM read strobe
- Rd_Addr  out  ADDR_WIDTH  result-RAM read address
- Rd_Data  in  DATA_WIDTH  RAM data, valid exactly one cycle after Rd_En
- Out_Data  out  DATA_WIDTH  output word
- Out_Index  out  ADDR_WIDTH  output bin index k
- Out_Last  out  1  high with the word for k = N_POINTS-1
- Out_Valid  out  1  output word valid
- Out_Ready  in  1  downstream accepts word when Out_Valid && Out_Ready

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- IDLE: Start latches Scale_En, Bit_Rev into frame registers, clears read counter rd_k and output counter out_k, goes RUN. Start in any other state is ignored.
- RUN: issues Rd_En with Rd_Addr = Bit_Rev ? bitreverse(rd_k) : rd_k, increments rd_k, only when (buffered words + reads in flight) < 2. After issuing read for rd_k = N_POINTS-1, goes DRAIN.
- Returned Rd_Data is processed and written into a 2-entry output FIFO tagged with its k.
- Scaling when frame Scale_En = 1: real and imaginary halves each arithmetic-shifted right by SHIFT independently (sign-extended, truncation toward minus infinity, no rounding); otherwise word passes unchanged. Result width stays 16 bits per half.
- Out_Data/Out_Index/Out_Last/Out_Valid driven from FIFO head; handshake pops head and increments out_k.
- DRAIN: no further reads; on handshake with Out_Last, goes DONE.
- DONE: Done = 1 for one cycle, Busy drops, returns IDLE. Start arriving in the DONE cycle is ignored.
- Output order is always natural k = 0..N_POINTS-1; Bit_Rev only affects Rd_Addr.
- Out_Data must hold stable while Out_Valid && !Out_Ready.

## Timing
- Reset values: Busy 0, Done 0, Rd_En 0, Rd_Addr 0, Out_Valid 0, Out_Last 0, Out_Data 0, Out_Index 0; state IDLE; FIFO empty.
- Reset mid-frame: all outputs return to reset values asynchronously; frame abandoned; data of in-flight read discarded.
- Start accepted at edge T0 -> Busy and first Rd_En (addr for k=0) high in cycle T0+1 -> data into FIFO at T0+2 edge -> Out_Valid high in cycle T0+3.
- With Out_Ready held 1: one word per cycle, 64 words in 64 consecutive cycles (T0+3 .. T0+66), Done in T0+67. No bubbles allowed.
- Out_Ready low: at most 2 reads outstanding/buffered; no word lost or duplicated; reads resume the cycle after buffer space frees.
- Rd_En is never asserted outside RUN; never more than N_POINTS reads per frame.

## Test plan
- RAM[a] = {a,a} per half, Scale_En 0, Bit_Rev 0, Out_Ready 1 -> Out_Data k = {k,k} for k = 0..63 on consecutive cycles, Out_Last only on k = 63, Done one cycle after.
- Same RAM, Bit_Rev 1 -> Rd_Addr sequence 0,32,16,48,8,...,63; Out_Index 0..63 in order; Out_Data for k=1 is {32,32}.
- Scale_En 1, halves 0x7FFF, 0x8000, 0xFFFF, 0x0040, 0x003F -> 0x01FF, 0xFE00, 0xFFFF, 0x0001, 0x0000.
- Random Out_Ready (50%) -> exactly 64 handshakes, data matches model, Out_Data stable while stalled, outstanding reads never exceed 2.
- Start pulses while Busy and in DONE cycle -> ignored; Scale_En toggled mid-frame -> no effect on current frame.
- nRst low at word 20, then new Start -> outputs zero during reset, new frame delivers k = 0..63 from start, no stale word.

Source files
------------

// File: rtl/fft_out_sequencer.sv
// fft_out_sequencer: unloads one FFT frame from the result RAM (natural or bit-reversed
// address order), optionally scales each half by 2^-SHIFT, and streams it over valid/ready.
module fft_out_sequencer #(
    parameter int N_POINTS   = 64,
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 32,
    parameter int SHIFT      = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  scale_en,
    input  logic                  bit_rev,
    output logic                  busy,
    output logic                  done,
    output logic                  rd_en,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [ADDR_WIDTH-1:0] out_index,
    output logic                  out_last,
    output logic                  out_valid,
    input  logic                  out_ready
);
    localparam int HW = DATA_WIDTH / 2;
    localparam logic [ADDR_WIDTH-1:0] LAST_K = ADDR_WIDTH'(N_POINTS - 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t                  state;
    logic                    frame_scale;
    logic                    frame_rev;
    logic [ADDR_WIDTH-1:0]   rd_k;
    logic [ADDR_WIDTH-1:0]   rd_rev;
    logic [ADDR_WIDTH-1:0]   fly_k;
    logic                    fly;
    logic [DATA_WIDTH-1:0]   fifo_data [2];
    logic [ADDR_WIDTH-1:0]   fifo_k [2];
    logic                    head;
    logic                    tail;
    logic [1:0]              count;
    logic                    pop;
    logic signed [HW-1:0]    re;
    logic signed [HW-1:0]    im;
    logic [DATA_WIDTH-1:0]   word;

    for (genvar i = 0; i < ADDR_WIDTH; i++) begin : g_rev
        assign rd_rev[i] = rd_k[ADDR_WIDTH-1-i];
    end

    assign re        = rd_data[DATA_WIDTH-1:HW];
    assign im        = rd_data[HW-1:0];
    assign word      = frame_scale ? {re >>> SHIFT, im >>> SHIFT} : rd_data;
    assign out_valid = count != 2'd0;
    assign pop       = out_valid && out_ready;
    assign out_data  = fifo_data[head];
    assign out_index = fifo_k[head];
    assign out_last  = out_valid && fifo_k[head] == LAST_K;
    assign rd_addr   = frame_rev ? rd_rev : rd_k;
    // Credit counts a same-cycle pop so a 2-deep buffer sustains one word per cycle
    // across the two-cycle read-to-buffer latency.
    assign rd_en     = state == RUN && (3'(count) + 3'(fly)) < (3'd2 + 3'(pop));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            busy         <= 1'b0;
            done         <= 1'b0;
            frame_scale  <= 1'b0;
            frame_rev    <= 1'b0;
            rd_k         <= '0;
            fly          <= 1'b0;
            fly_k        <= '0;
            fifo_data[0] <= '0;
            fifo_data[1] <= '0;
            fifo_k[0]    <= '0;
            fifo_k[1]    <= '0;
            head         <= 1'b0;
            tail         <= 1'b0;
            count        <= '0;
        end else begin
            done  <= 1'b0;
            fly   <= rd_en;
            count <= count + 2'(fly) - 2'(pop);
            if (rd_en) begin
                fly_k <= rd_k;
                rd_k  <= rd_k + 1'b1;
            end
            if (fly) begin
                fifo_data[tail] <= word;
                fifo_k[tail]    <= fly_k;
                tail            <= ~tail;
            end
            if (pop)
                head <= ~head;
            case (state)
                IDLE: if (start) begin
                    state       <= RUN;
                    busy        <= 1'b1;
                    frame_scale <= scale_en;
                    frame_rev   <= bit_rev;
                    rd_k        <= '0;
                end
                RUN: if (rd_en && rd_k == LAST_K)
                    state <= DRAIN;
                DRAIN: if (pop && out_last) begin
                    state <= DONE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fft_out_sequencer.sv
// tb_fft_out_sequencer: directed frames against a behavioural result RAM and an
// independent word model, plus reset, backpressure and ignored-start sequences.
module tb_fft_out_sequencer;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        scale_en = 1'b0;
    logic        bit_rev = 1'b0;
    logic        out_ready = 1'b0;
    logic        busy, done, rd_en, out_last, out_valid;
    logic [5:0]  rd_addr, out_index;
    logic [31:0] rd_data, out_data;

    typedef struct {
        logic [31:0] word;
        logic [31:0] exp;
    } vec_t;
    vec_t vecs[5];

    logic [31:0] ram [64];
    logic [31:0] rd_q = '0;
    int          pass_cnt = 0;
    int          total_cnt = 0;
    int          cyc = 0;
    logic [31:0] data_q[$];
    logic [5:0]  idx_q[$];
    logic [5:0]  addr_q[$];
    logic        last_q[$];
    int          n_rd, n_pop, max_outst, stall_err, rd_outside, done_cnt;
    int          fv_cyc, done_cyc, lp_cyc, start_cyc;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_data;
    logic [5:0]  prev_idx;

    fft_out_sequencer dut (
        .clk(clk), .rst_n(rst_n), .start(start), .scale_en(scale_en), .bit_rev(bit_rev),
        .busy(busy), .done(done), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .out_data(out_data), .out_index(out_index), .out_last(out_last),
        .out_valid(out_valid), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rd_en) rd_q <= ram[rd_addr];
    end
    assign rd_data = rd_q;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (n_rd - n_pop > max_outst) max_outst = n_rd - n_pop;
            if (rd_en) begin
                addr_q.push_back(rd_addr);
                n_rd++;
                if (!busy) rd_outside++;
            end
            if (prev_stall && (!out_valid || out_data !== prev_data || out_index !== prev_idx))
                stall_err++;
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_idx   = out_index;
            if (out_valid && fv_cyc < 0) fv_cyc = cyc;
            if (out_valid && out_ready) begin
                data_q.push_back(out_data);
                idx_q.push_back(out_index);
                last_q.push_back(out_last);
                n_pop++;
                if (out_last) lp_cyc = cyc;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    function automatic logic [5:0] br6(input logic [5:0] a);
        logic [5:0] r;
        for (int i = 0; i < 6; i++) r[i] = a[5-i];
        return r;
    endfunction

    function automatic logic [15:0] sc16(input logic [15:0] h);
        return {{6{h[15]}}, h[15:6]};
    endfunction

    function automatic logic [31:0] model(input int k, input logic sc, input logic rv);
        logic [31:0] w;
        w = ram[rv ? br6(6'(k)) : 6'(k)];
        return sc ? {sc16(w[31:16]), sc16(w[15:0])} : w;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_rd_en"}, 32'(rd_en), 0);
        chk({tag, "_rd_addr"}, 32'(rd_addr), 0);
        chk({tag, "_out_valid"}, 32'(out_valid), 0);
        chk({tag, "_out_last"}, 32'(out_last), 0);
        chk({tag, "_out_data"}, out_data, 0);
        chk({tag, "_out_index"}, 32'(out_index), 0);
    endtask

    task automatic clear_mon();
        data_q.delete(); idx_q.delete(); addr_q.delete(); last_q.delete();
        n_rd = 0; n_pop = 0; max_outst = 0; stall_err = 0; rd_outside = 0; done_cnt = 0;
        fv_cyc = -1; done_cyc = -1; lp_cyc = -1;
    endtask

    task automatic run_frame(input logic sc, input logic rv, input bit rnd, input bit poke_busy,
                             input bit poke_done, input int abort_at);
        bit got;
        got = 1'b0;
        @(posedge clk); #1;
        clear_mon();
        start     = 1'b1;
        scale_en  = sc;
        bit_rev   = rv;
        out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        start_cyc = cyc;
        for (int n = 0; n < 600 && !got; n++) begin
            @(posedge clk); #1;
            start     = poke_busy && n == 30;
            scale_en  = ~sc;
            bit_rev   = ~rv;
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (done) begin
                got   = 1'b1;
                start = poke_done;
            end
            if (abort_at >= 0 && n_pop >= abort_at) return;
        end
        chk("done_seen", 32'(got), 1);
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy_after_done", 32'(busy), 0);
        repeat (3) @(posedge clk);
        #1;
        chk("idle_after_done", 32'(busy), 0);
    endtask

    task automatic check_frame(input logic sc, input logic rv);
        chk("handshakes", 32'(data_q.size()), 64);
        for (int i = 0; i < 64 && i < data_q.size(); i++) begin
            chk($sformatf("data[%0d]", i), data_q[i], model(i, sc, rv));
            chk($sformatf("index[%0d]", i), 32'(idx_q[i]), 32'(i));
            chk($sformatf("last[%0d]", i), 32'(last_q[i]), 32'(i == 63));
        end
        chk("reads", 32'(n_rd), 64);
        for (int i = 0; i < 64 && i < addr_q.size(); i++)
            chk($sformatf("rd_addr[%0d]", i), 32'(addr_q[i]), 32'(rv ? br6(6'(i)) : 6'(i)));
        chk("done_pulses", 32'(done_cnt), 1);
        chk("stall_stable_errs", 32'(stall_err), 0);
        chk("outstanding_le2", 32'(max_outst <= 2), 1);
        chk("rd_outside_run", 32'(rd_outside), 0);
    endtask

    initial begin
        vecs[0] = '{32'h7FFF8000, 32'h01FFFE00};
        vecs[1] = '{32'hFFFF0040, 32'hFFFF0001};
        vecs[2] = '{32'h003F7FFF, 32'h000001FF};
        vecs[3] = '{32'h8000003F, 32'hFE000000};
        vecs[4] = '{32'h0040FFFF, 32'h0001FFFF};
        for (int a = 0; a < 64; a++) ram[a] = {16'(a), 16'(a)};
        clear_mon();

        repeat (3) @(posedge clk);
        #1;
        chk_idle_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        run_frame(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, -1);
        check_frame(1'b0, 1'b0);
        chk("first_valid_latency", 32'(fv_cyc - start_cyc), 3);
        chk("done_latency", 32'(done_cyc - start_cyc), 67);
        chk("burst_no_bubbles", 32'(lp_cyc - fv_cyc), 63);

        run_frame(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, -1);
        check_frame(1'b0, 1'b1);
        chk("bitrev_data_k1", data_q[1], 32'h00200020);
        chk("bitrev_addr1", 32'(addr_q[1]), 32);
        chk("bitrev_addr2", 32'(addr_q[2]), 16);
        chk("bitrev_addr3", 32'(addr_q[3]), 48);
        chk("bitrev_addr63", 32'(addr_q[63]), 63);

        for (int i = 0; i < 5; i++) ram[i] = vecs[i].word;
        run_frame(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, -1);
        check_frame(1'b1, 1'b0);
        for (int i = 0; i < 5; i++)
            chk($sformatf("scale_vec[%0d]", i), data_q[i], vecs[i].exp);
        for (int a = 0; a < 5; a++) ram[a] = {16'(a), 16'(a)};

        run_frame(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, -1);
        check_frame(1'b0, 1'b0);

        run_frame(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 20);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_idle_outputs("midreset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run_frame(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, -1);
        check_frame(1'b0, 1'b1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
